// File: rtl/periph_arb_pkg.sv
// Shared types for the two-master peripheral arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package periph_arb_pkg;

  // The request record carries the widest supported address; each arbiter
  // instance uses only the low ADDR_W bits, so ADDR_W must not exceed this.
  localparam int ARB_ADDR_W_MAX = 64;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_BE_W       = 4;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_master_t;

  typedef struct packed {
    logic [ARB_ADDR_W_MAX-1:0] addr;
    logic                      we;
    logic [ARB_BE_W-1:0]       be;
    logic [ARB_DATA_W-1:0]     wdata;
  } arb_req_t;

  // The master that is not m.
  function automatic arb_master_t arb_other(input arb_master_t m);
    return (m == ARB_M0) ? ARB_M1 : ARB_M0;
  endfunction

endpackage

// File: rtl/periph_arb_picker.sv
// Chooses which master owns the slave bus this cycle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the winner is only meaningful when a request is present.
// Build option: PERIPH_ARB_RR_EN selects round-robin ties, otherwise m0 wins ties.
module periph_arb_picker
  import periph_arb_pkg::*;
(
  input  logic        m0_req,
  input  logic        m1_req,
  input  arb_master_t last_q,
  output arb_master_t winner
);

`ifndef PERIPH_ARB_RR_EN
  // Fixed priority never consults the previous winner.
  logic last_unused;
  assign last_unused = last_q;
`endif

  // A lone requester always wins; a tie is resolved by the build's policy.
  always_comb begin
    winner = ARB_M0;
    if (m1_req && !m0_req) begin
      winner = ARB_M1;
    end else if (m0_req && m1_req) begin
`ifdef PERIPH_ARB_RR_EN
      winner = arb_other(last_q);
`else
      winner = ARB_M0;
`endif
    end
  end

endmodule

// File: rtl/periph_arbiter.sv
// Two-master to one-slave peripheral bus arbiter with response routing.
// Latency: request/grant combinational; response routed in the cycle the slave returns it (one after accept).
// Backpressure: a master keeps req asserted until it sees gnt; the slave stalls by holding s_gnt low.
// Build option: PERIPH_ARB_RR_EN enables round-robin tie breaking (default: m0 priority).
module periph_arbiter
  import periph_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [3:0]        m0_be,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m0_wdata,
  input  logic [31:0]       m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [31:0]       m0_rdata,
  output logic [31:0]       m1_rdata,
  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_we,
  output logic [3:0]        s_be,
  output logic [31:0]       s_wdata,
  input  logic              s_gnt,
  input  logic              s_rvalid,
  input  logic [31:0]       s_rdata,
  output logic              arb_err
);

  arb_req_t                  m0_pkt;
  arb_req_t                  m1_pkt;
  arb_req_t                  win_pkt;
  arb_master_t               winner;
  arb_master_t               owner_q;
  arb_master_t               last_q;
  logic                      accept;
  logic                      stray;
  logic                      pend_q;
  logic                      arb_err_q;
  logic [ARB_ADDR_W_MAX-1:0] win_addr_unused;

  // Gather each master's request fields into a common record.
  always_comb begin
    m0_pkt                = '0;
    m0_pkt.addr[ADDR_W-1:0] = m0_addr;
    m0_pkt.we             = m0_we;
    m0_pkt.be             = m0_be;
    m0_pkt.wdata          = m0_wdata;
    m1_pkt                = '0;
    m1_pkt.addr[ADDR_W-1:0] = m1_addr;
    m1_pkt.we             = m1_we;
    m1_pkt.be             = m1_be;
    m1_pkt.wdata          = m1_wdata;
  end

  periph_arb_picker u_picker (
    .m0_req (m0_req),
    .m1_req (m1_req),
    .last_q (last_q),
    .winner (winner)
  );

  assign s_req = m0_req | m1_req;

  // Forward the winner's request; the bus is held at zero when nobody asks.
  always_comb begin
    win_pkt = '0;
    if (s_req) begin
      win_pkt = (winner == ARB_M1) ? m1_pkt : m0_pkt;
    end
  end

  assign s_addr          = win_pkt.addr[ADDR_W-1:0];
  assign win_addr_unused = win_pkt.addr;
  assign s_we            = win_pkt.we;
  assign s_be            = win_pkt.be;
  assign s_wdata         = win_pkt.wdata;

  // Grants are suppressed while reset is asserted so nothing is accepted.
  assign accept = s_req & s_gnt & rst_n;
  assign m0_gnt = accept & (winner == ARB_M0);
  assign m1_gnt = accept & (winner == ARB_M1);

  // Track the single outstanding response and which master it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      owner_q <= ARB_M0;
    end else begin
      pend_q <= accept;
      if (accept) begin
        owner_q <= winner;
      end
    end
  end

`ifdef PERIPH_ARB_RR_EN
  // Remember the last accepted master so the next tie goes to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ARB_M1;
    end else if (accept) begin
      last_q <= winner;
    end
  end
`else
  // Fixed priority has no history; the picker ignores this value.
  assign last_q = ARB_M1;
`endif

  // A response with nothing outstanding is dropped and flagged until reset.
  assign stray = s_rvalid & ~pend_q;

  // Sticky error flag for stray responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_err_q <= 1'b0;
    end else if (stray) begin
      arb_err_q <= 1'b1;
    end
  end

  assign arb_err = arb_err_q;

  // Route the response using the owner recorded at accept time.
  assign m0_rvalid = s_rvalid & pend_q & (owner_q == ARB_M0);
  assign m1_rvalid = s_rvalid & pend_q & (owner_q == ARB_M1);

  // Read data is broadcast; masters qualify it with their own rvalid.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_periph_arbiter.sv
// Directed bench for periph_arbiter: vector table plus corner-case sequences.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Tie expectations follow PERIPH_ARB_RR_EN when it is defined for the build.
module tb_periph_arbiter;

  localparam logic [31:0] M0W = 32'h1111_0000;
  localparam logic [31:0] M1W = 32'h2222_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_gnt, s_rvalid;
  logic [31:0] s_rdata;
  logic        arb_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  periph_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_be(m0_be), .m1_be(m1_be),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .arb_err(arb_err)
  );

  typedef struct {
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;
    logic        e_s_req;
    logic [31:0] e_s_addr;
    logic        e_s_we;
    logic [3:0]  e_s_be;
    logic [31:0] e_s_wdata;
    logic        e_m0_gnt, e_m1_gnt, e_m0_rvalid, e_m1_rvalid, e_err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int g_exp[6];

  initial begin
    m0_we = 1'b1; m0_be = 4'hF; m0_wdata = M0W;
    m1_we = 1'b0; m1_be = 4'h3; m1_wdata = M1W;
    idle_inputs();
    rst_n = 1'b0;

    // Vector table: {m0_req,m1_req,m0_addr,m1_addr,s_gnt,s_rvalid,s_rdata,
    //                s_req,s_addr,s_we,s_be,s_wdata,m0_gnt,m1_gnt,m0_rv,m1_rv,err}
    vt[0]  = '{0,0,32'h55,32'h66,0,0,32'h0,        0,32'h0, 0,4'h0,32'h0, 0,0,0,0,0};
    vt[1]  = '{0,1,32'h99,32'h04,1,0,32'h0,        1,32'h04,0,4'h3,M1W,   0,1,0,0,0};
    vt[2]  = '{0,0,32'h0, 32'h0, 0,1,32'hA5A5_0001,0,32'h0, 0,4'h0,32'h0, 0,0,0,1,0};
    vt[3]  = '{1,0,32'h10,32'h0, 0,0,32'h0,        1,32'h10,1,4'hF,M0W,   0,0,0,0,0};
    vt[4]  = '{1,0,32'h10,32'h0, 0,0,32'h0,        1,32'h10,1,4'hF,M0W,   0,0,0,0,0};
    vt[5]  = '{1,0,32'h10,32'h0, 0,0,32'h0,        1,32'h10,1,4'hF,M0W,   0,0,0,0,0};
    vt[6]  = '{1,0,32'h10,32'h0, 1,0,32'h0,        1,32'h10,1,4'hF,M0W,   1,0,0,0,0};
    vt[7]  = '{0,0,32'h0, 32'h0, 0,1,32'hBEEF_0007,0,32'h0, 0,4'h0,32'h0, 0,0,1,0,0};
    vt[8]  = '{1,0,32'h20,32'h0, 1,0,32'h0,        1,32'h20,1,4'hF,M0W,   1,0,0,0,0};
    vt[9]  = '{0,1,32'h0, 32'h30,1,1,32'hCAFE_0009,1,32'h30,0,4'h3,M1W,   0,1,1,0,0};
    vt[10] = '{0,0,32'h0, 32'h0, 0,1,32'h1234_000A,0,32'h0, 0,4'h0,32'h0, 0,0,0,1,0};

    // During reset: requests and a slave response must produce nothing.
    #1;
    m0_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b1;
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_arb_err", arb_err, 0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      m0_req = vt[i].m0_req; m1_req = vt[i].m1_req;
      m0_addr = vt[i].m0_addr; m1_addr = vt[i].m1_addr;
      s_gnt = vt[i].s_gnt; s_rvalid = vt[i].s_rvalid; s_rdata = vt[i].s_rdata;
      @(negedge clk);
      chk($sformatf("v%0d_s_req", i), s_req, vt[i].e_s_req);
      chk($sformatf("v%0d_s_addr", i), s_addr, vt[i].e_s_addr);
      chk($sformatf("v%0d_s_we", i), s_we, vt[i].e_s_we);
      chk($sformatf("v%0d_s_be", i), s_be, vt[i].e_s_be);
      chk($sformatf("v%0d_s_wdata", i), s_wdata, vt[i].e_s_wdata);
      chk($sformatf("v%0d_m0_gnt", i), m0_gnt, vt[i].e_m0_gnt);
      chk($sformatf("v%0d_m1_gnt", i), m1_gnt, vt[i].e_m1_gnt);
      chk($sformatf("v%0d_m0_rvalid", i), m0_rvalid, vt[i].e_m0_rvalid);
      chk($sformatf("v%0d_m1_rvalid", i), m1_rvalid, vt[i].e_m1_rvalid);
      chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vt[i].s_rdata);
      chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vt[i].s_rdata);
      chk($sformatf("v%0d_arb_err", i), arb_err, vt[i].e_err);
    end

    // Tie: both masters request for 4 cycles, then only m1, then idle.
    // Expected grant per cycle: 0 = m0, 1 = m1, 2 = none.
`ifdef PERIPH_ARB_RR_EN
    g_exp = '{0, 1, 0, 1, 1, 2};
`else
    g_exp = '{0, 0, 0, 0, 1, 2};
`endif
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      m0_req = (k < 4); m1_req = (k < 5);
      m0_addr = 32'h100; m1_addr = 32'h200;
      s_gnt = 1'b1;
      s_rvalid = (k > 0);
      s_rdata = 32'h7700_0000 + k;
      @(negedge clk);
      chk($sformatf("tie%0d_m0_gnt", k), m0_gnt, (g_exp[k] == 0));
      chk($sformatf("tie%0d_m1_gnt", k), m1_gnt, (g_exp[k] == 1));
      chk($sformatf("tie%0d_s_addr", k), s_addr,
          (g_exp[k] == 0) ? 32'h100 : (g_exp[k] == 1) ? 32'h200 : 32'h0);
      if (k > 0) begin
        chk($sformatf("tie%0d_m0_rvalid", k), m0_rvalid, (g_exp[k-1] == 0));
        chk($sformatf("tie%0d_m1_rvalid", k), m1_rvalid, (g_exp[k-1] == 1));
      end
    end
    chk("tie_arb_err", arb_err, 0);

    // Stray response with nothing outstanding.
    reset_pulse();
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_0001;
    @(negedge clk);
    chk("stray_m0_rvalid", m0_rvalid, 0);
    chk("stray_m1_rvalid", m1_rvalid, 0);
    chk("stray_err_before_edge", arb_err, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      s_rvalid = 1'b0;
      @(negedge clk);
      chk($sformatf("stray_err_held%0d", k), arb_err, 1);
    end
    reset_pulse();
    @(negedge clk);
    chk("stray_err_cleared", arb_err, 0);

    // Reset lands on the cycle after an accept: the response is discarded.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 32'h40; s_gnt = 1'b1;
    @(negedge clk);
    chk("midrst_accept_gnt", m0_gnt, 1);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hFACE_0001;
    @(negedge clk);
    chk("midrst_m0_rvalid", m0_rvalid, 0);
    chk("midrst_m1_rvalid", m1_rvalid, 0);
    chk("midrst_arb_err", arb_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_rvalid = 1'b0;
    @(negedge clk);
    chk("postrst_m0_rvalid", m0_rvalid, 0);
    chk("postrst_arb_err", arb_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
